// File: rtl/defines.v
// Shared CSR addresses, reset polarity and mstatus field positions used by the trap sequencer.
`ifndef TRAP_SEQ_DEFINES_V
`define TRAP_SEQ_DEFINES_V

`define RST      1'b0

`define CSR_MSTATUS  12'h300
`define CSR_MTVEC    12'h305
`define CSR_MEPC     12'h341
`define CSR_MCAUSE   12'h342
`define CSR_MDISABLE 12'h000

`define MIE      3
`define MPIE     7
`define MPP_HI   12
`define MPP_LO   11

`endif

// File: rtl/trap_seq.sv
// Trap entry / MRET sequencer: steals the csregfile port for a few cycles to save
// or restore mepc/mcause/mstatus and redirects the PC when done.
`include "defines.v"

module trap_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        trap_req,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic        mret_req,
   input  logic [11:0] core_csr_waddr,
   input  logic [31:0] core_csr_wdata,
   input  logic [11:0] core_csr_raddr,
   input  logic [31:0] csr_rdata,
   output logic [11:0] csr_waddr_o,
   output logic [31:0] csr_wdata_o,
   output logic [11:0] csr_raddr_o,
   output logic        ack_o,
   output logic        stall_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] T_EPC    = 3'd1;
   localparam logic [2:0] T_CAUSE  = 3'd2;
   localparam logic [2:0] T_STATUS = 3'd3;
   localparam logic [2:0] T_VEC    = 3'd4;
   localparam logic [2:0] M_STATUS = 3'd5;
   localparam logic [2:0] M_EPC    = 3'd6;

   logic [2:0]  state;
   logic [2:0]  state_nx;
   logic [31:0] pc_q;
   logic [31:0] cause_q;
   logic [31:0] shadow_q;
   logic [31:0] redirect_pc_q;

   logic        in_reset;
   logic        take_trap;
   logic        take_mret;
   logic [31:0] status_trap;
   logic [31:0] status_mret;
   logic [31:0] vec_pc;
   logic [31:0] redirect_target;

   assign in_reset  = (rst == `RST);
   // Requests are only looked at in IDLE; a trap always beats a simultaneous MRET.
   assign take_trap = !in_reset && (state == IDLE) && trap_req;
   assign take_mret = !in_reset && (state == IDLE) && !trap_req && mret_req;

   always_comb begin
      status_trap                  = shadow_q;
      status_trap[`MPIE]           = shadow_q[`MIE];
      status_trap[`MIE]            = 1'b0;
      status_trap[`MPP_HI:`MPP_LO] = 2'b11;

      status_mret                  = csr_rdata;
      status_mret[`MIE]            = csr_rdata[`MPIE];
      status_mret[`MPIE]           = 1'b1;
      status_mret[`MPP_HI:`MPP_LO] = 2'b11;
   end

   // Vectored mode only offsets interrupts; the shift drops cause[31:30] as intended.
   always_comb begin
      vec_pc = csr_rdata & ~32'h3;
      if ((csr_rdata[1:0] == 2'b01) && cause_q[31])
         vec_pc = vec_pc + (cause_q << 2);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (take_trap)
               state_nx = T_EPC;
            else if (take_mret)
               state_nx = M_STATUS;
         end
         T_EPC:    state_nx = T_CAUSE;
         T_CAUSE:  state_nx = T_STATUS;
         T_STATUS: state_nx = T_VEC;
         T_VEC:    state_nx = IDLE;
         M_STATUS: state_nx = M_EPC;
         M_EPC:    state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      csr_waddr_o     = `CSR_MDISABLE;
      csr_wdata_o     = core_csr_wdata;
      csr_raddr_o     = `CSR_MDISABLE;
      redirect_o      = 1'b0;
      redirect_target = redirect_pc_q;
      case (state)
         IDLE: begin
            csr_raddr_o = core_csr_raddr;
            if (!(trap_req || mret_req))
               csr_waddr_o = core_csr_waddr;
         end
         T_EPC: begin
            csr_waddr_o = `CSR_MEPC;
            csr_wdata_o = pc_q & ~32'h3;
            csr_raddr_o = `CSR_MSTATUS;
         end
         T_CAUSE: begin
            csr_waddr_o = `CSR_MCAUSE;
            csr_wdata_o = cause_q;
         end
         T_STATUS: begin
            csr_waddr_o = `CSR_MSTATUS;
            csr_wdata_o = status_trap;
         end
         T_VEC: begin
            csr_raddr_o     = `CSR_MTVEC;
            redirect_o      = 1'b1;
            redirect_target = vec_pc;
         end
         M_STATUS: begin
            csr_raddr_o = `CSR_MSTATUS;
            csr_waddr_o = `CSR_MSTATUS;
            csr_wdata_o = status_mret;
         end
         M_EPC: begin
            csr_raddr_o     = `CSR_MEPC;
            redirect_o      = 1'b1;
            redirect_target = csr_rdata & ~32'h3;
         end
         default: ;
      endcase
      if (in_reset) begin
         csr_waddr_o = `CSR_MDISABLE;
         redirect_o  = 1'b0;
      end
   end

   assign ack_o         = take_trap || take_mret;
   assign stall_o       = !in_reset && (state != IDLE);
   assign redirect_pc_o = redirect_o ? redirect_target : redirect_pc_q;

   always_ff @(posedge clk) begin
      if (in_reset) begin
         state         <= IDLE;
         pc_q          <= 32'd0;
         cause_q       <= 32'd0;
         shadow_q      <= 32'd0;
         redirect_pc_q <= 32'd0;
      end else begin
         state <= state_nx;
         if (take_trap) begin
            pc_q    <= trap_pc;
            cause_q <= trap_cause;
         end
         if (state == T_EPC)
            shadow_q <= csr_rdata;
         if (redirect_o)
            redirect_pc_q <= redirect_target;
      end
   end

endmodule

// File: tb/tb_trap_seq.sv
// Bench for trap_seq: a small CSR file around the DUT, a scoreboard of expected CSR
// writes and redirects, and one task per scenario.
`timescale 1ns/1ps

module tb_trap_seq;

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MDIS    = 12'h000;

   logic        clk;
   logic        rst;
   logic        trap_req;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;
   logic        mret_req;
   logic [11:0] core_csr_waddr;
   logic [31:0] core_csr_wdata;
   logic [11:0] core_csr_raddr;
   logic [31:0] csr_rdata;
   logic [11:0] csr_waddr_o;
   logic [31:0] csr_wdata_o;
   logic [11:0] csr_raddr_o;
   logic        ack_o;
   logic        stall_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;

   int total = 0;
   int bad   = 0;

   logic [43:0] exp_q[$];
   logic [31:0] exp_rd_q[$];

   logic [31:0] csr_mem [0:4095];
   logic        bd_we;
   logic [11:0] bd_addr;
   logic [31:0] bd_data;

   trap_seq dut (
      .clk            (clk),
      .rst            (rst),
      .trap_req       (trap_req),
      .trap_pc        (trap_pc),
      .trap_cause     (trap_cause),
      .mret_req       (mret_req),
      .core_csr_waddr (core_csr_waddr),
      .core_csr_wdata (core_csr_wdata),
      .core_csr_raddr (core_csr_raddr),
      .csr_rdata      (csr_rdata),
      .csr_waddr_o    (csr_waddr_o),
      .csr_wdata_o    (csr_wdata_o),
      .csr_raddr_o    (csr_raddr_o),
      .ack_o          (ack_o),
      .stall_o        (stall_o),
      .redirect_o     (redirect_o),
      .redirect_pc_o  (redirect_pc_o)
   );

   // clock / reset-free environment: clock and the csregfile stand-in
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign csr_rdata = csr_mem[csr_raddr_o];

   always @(posedge clk) begin
      if (bd_we)
         csr_mem[bd_addr] <= bd_data;
      else if (csr_waddr_o != A_MDIS)
         csr_mem[csr_waddr_o] <= csr_wdata_o;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // scoreboard: every CSR write and redirect the DUT produces must match the queue head
   always @(negedge clk) begin
      if (csr_waddr_o !== A_MDIS) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL csr_write: got addr=%h data=%h, none expected", csr_waddr_o, csr_wdata_o);
         end else begin
            logic [43:0] e;
            e = exp_q.pop_front();
            if ({csr_waddr_o, csr_wdata_o} !== e) begin
               bad++;
               $display("FAIL csr_write: got addr=%h data=%h, expected addr=%h data=%h",
                        csr_waddr_o, csr_wdata_o, e[43:32], e[31:0]);
            end
         end
      end
      if (redirect_o === 1'b1) begin
         total++;
         if (exp_rd_q.size() == 0) begin
            bad++;
            $display("FAIL redirect: got pc=%h, none expected", redirect_pc_o);
         end else begin
            logic [31:0] r;
            r = exp_rd_q.pop_front();
            if (redirect_pc_o !== r) begin
               bad++;
               $display("FAIL redirect: got pc=%h, expected %h", redirect_pc_o, r);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bd_write(input logic [11:0] a, input logic [31:0] d);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = d;
      tick();
      bd_we   = 1'b0;
   endtask

   function automatic logic [31:0] model_trap_status(input logic [31:0] s);
      logic [31:0] r;
      r        = s;
      r[7]     = s[3];
      r[3]     = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

   function automatic logic [31:0] model_vec(input logic [31:0] tv, input logic [31:0] c);
      logic [31:0] r;
      r = {tv[31:2], 2'b00};
      if (tv[1:0] == 2'b01 && c[31])
         r = r + {c[29:0], 2'b00};
      return r;
   endfunction

   // mode 0: plain, 1: MRET and core write alongside the trap, 2: core/MRET poked while busy
   task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] exp_ms, input logic [31:0] exp_vec, input int mode);
      exp_q.push_back({A_MEPC, pc & ~32'h3});
      exp_q.push_back({A_MCAUSE, cause});
      exp_q.push_back({A_MSTATUS, exp_ms});
      exp_rd_q.push_back(exp_vec);
      trap_req   = 1'b1;
      trap_pc    = pc;
      trap_cause = cause;
      if (mode == 1) begin
         mret_req       = 1'b1;
         core_csr_waddr = A_MEPC;
         core_csr_wdata = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      total++;
      if (ack_o !== 1'b1 || csr_waddr_o !== A_MDIS) begin
         bad++;
         $display("FAIL trap_accept: ack=%b waddr=%h, expected ack=1 waddr=%h", ack_o, csr_waddr_o, A_MDIS);
      end
      tick();
      trap_req       = 1'b0;
      trap_pc        = $urandom;
      trap_cause     = $urandom;
      mret_req       = 1'b0;
      core_csr_waddr = A_MDIS;
      for (int c = 1; c <= 4; c++) begin
         if (mode == 2) begin
            mret_req       = 1'b1;
            core_csr_waddr = A_MSTATUS;
            core_csr_wdata = 32'hFFFF_FFFF;
         end
         @(negedge clk);
         total++;
         if (stall_o !== 1'b1 || redirect_o !== (c == 4)) begin
            bad++;
            $display("FAIL trap_busy%0d: stall=%b redirect=%b, expected stall=1 redirect=%b",
                     c, stall_o, redirect_o, (c == 4));
         end
         if (mode == 2 && c == 2) begin
            total++;
            if (csr_waddr_o !== A_MCAUSE) begin
               bad++;
               $display("FAIL busy_block: waddr=%h in cause state, expected %h", csr_waddr_o, A_MCAUSE);
            end
         end
         tick();
      end
      mret_req       = 1'b0;
      core_csr_waddr = A_MDIS;
      @(negedge clk);
      total++;
      if (stall_o !== 1'b0 || ack_o !== 1'b0 || redirect_pc_o !== exp_vec) begin
         bad++;
         $display("FAIL trap_done: stall=%b ack=%b pc=%h, expected stall=0 ack=0 pc=%h",
                  stall_o, ack_o, redirect_pc_o, exp_vec);
      end
      tick();
   endtask

   task automatic do_mret(input logic [31:0] ms, input logic [31:0] epc,
                          input logic [31:0] exp_ms, input logic [31:0] exp_pc);
      bd_write(A_MSTATUS, ms);
      bd_write(A_MEPC, epc);
      exp_q.push_back({A_MSTATUS, exp_ms});
      exp_rd_q.push_back(exp_pc);
      mret_req = 1'b1;
      @(negedge clk);
      total++;
      if (ack_o !== 1'b1) begin
         bad++;
         $display("FAIL mret_accept: ack=%b, expected 1", ack_o);
      end
      tick();
      mret_req = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         total++;
         if (stall_o !== 1'b1 || redirect_o !== (c == 2)) begin
            bad++;
            $display("FAIL mret_busy%0d: stall=%b redirect=%b, expected stall=1 redirect=%b",
                     c, stall_o, redirect_o, (c == 2));
         end
         tick();
      end
      @(negedge clk);
      total++;
      if (stall_o !== 1'b0 || redirect_pc_o !== exp_pc) begin
         bad++;
         $display("FAIL mret_done: stall=%b pc=%h, expected stall=0 pc=%h", stall_o, redirect_pc_o, exp_pc);
      end
      tick();
   endtask

   task automatic test_reset();
      rst            = 1'b0;
      trap_req       = 1'b1;
      trap_pc        = 32'h0;
      trap_cause     = 32'h0;
      mret_req       = 1'b0;
      core_csr_waddr = A_MSTATUS;
      core_csr_wdata = 32'h1234_5678;
      core_csr_raddr = A_MDIS;
      bd_we          = 1'b0;
      bd_addr        = A_MDIS;
      bd_data        = 32'h0;
      tick();
      tick();
      @(negedge clk);
      total++;
      if (stall_o !== 1'b0 || ack_o !== 1'b0 || redirect_o !== 1'b0 ||
          redirect_pc_o !== 32'h0 || csr_waddr_o !== A_MDIS) begin
         bad++;
         $display("FAIL reset: stall=%b ack=%b redir=%b pc=%h waddr=%h, expected 0 0 0 0 %h",
                  stall_o, ack_o, redirect_o, redirect_pc_o, csr_waddr_o, A_MDIS);
      end
      tick();
      rst            = 1'b1;
      trap_req       = 1'b0;
      core_csr_waddr = A_MDIS;
      tick();
   endtask

   task automatic test_passthrough();
      core_csr_waddr = A_MSTATUS;
      core_csr_wdata = 32'h0000_55AA;
      core_csr_raddr = A_MTVEC;
      exp_q.push_back({A_MSTATUS, 32'h0000_55AA});
      @(negedge clk);
      total++;
      if (csr_waddr_o !== A_MSTATUS || csr_wdata_o !== 32'h0000_55AA ||
          csr_raddr_o !== A_MTVEC || stall_o !== 1'b0 || ack_o !== 1'b0) begin
         bad++;
         $display("FAIL passthrough: waddr=%h wdata=%h raddr=%h stall=%b ack=%b, expected %h 000055aa %h 0 0",
                  csr_waddr_o, csr_wdata_o, csr_raddr_o, stall_o, ack_o, A_MSTATUS, A_MTVEC);
      end
      tick();
      core_csr_waddr = A_MDIS;
      core_csr_raddr = A_MDIS;
   endtask

   task automatic test_trap_basic();
      bd_write(A_MSTATUS, 32'h0000_0008);
      bd_write(A_MTVEC, 32'h0000_0100);
      do_trap(32'h0000_2006, 32'h0000_0002, 32'h0000_1880, 32'h0000_0100, 0);
   endtask

   task automatic test_vectored();
      bd_write(A_MSTATUS, 32'h0);
      bd_write(A_MTVEC, 32'h0000_0101);
      do_trap(32'h0000_3000, 32'h8000_0007, 32'h0000_1800, 32'h0000_011C, 0);
      do_trap(32'h0000_3010, 32'h0000_0002, 32'h0000_1800, 32'h0000_0100, 0);
      bd_write(A_MSTATUS, 32'h0);
      bd_write(A_MTVEC, 32'h0000_0100);
      do_trap(32'h0000_3020, 32'h8000_0003, 32'h0000_1800, 32'h0000_0100, 0);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] ms, tv, c, pc;
         ms = $urandom;
         tv = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
         c  = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) c[31] = 1'b1;
         pc = $urandom;
         bd_write(A_MSTATUS, ms);
         bd_write(A_MTVEC, tv);
         do_trap(pc, c, model_trap_status(ms), model_vec(tv, c), 0);
      end
   endtask

   task automatic test_mret();
      do_mret(32'h0000_1880, 32'h0000_2004, 32'h0000_1888, 32'h0000_2004);
      do_mret(32'h0000_0000, 32'h0000_8003, 32'h0000_1880, 32'h0000_8000);
   endtask

   task automatic test_simultaneous();
      bd_write(A_MSTATUS, 32'h0000_0008);
      bd_write(A_MTVEC, 32'h0000_0200);
      do_trap(32'h0000_5004, 32'h0000_000B, 32'h0000_1880, 32'h0000_0200, 1);
   endtask

   task automatic test_back_to_back();
      bd_write(A_MSTATUS, 32'h0000_0000);
      bd_write(A_MTVEC, 32'h0000_0300);
      do_trap(32'h0000_6000, 32'h0000_0004, 32'h0000_1800, 32'h0000_0300, 2);
      do_trap(32'h0000_6100, 32'h0000_0005, 32'h0000_1800, 32'h0000_0300, 0);
   endtask

   task automatic test_reset_mid();
      bd_write(A_MSTATUS, 32'h0000_0008);
      bd_write(A_MTVEC, 32'h0000_0100);
      exp_q.push_back({A_MEPC, 32'h0000_4000});
      trap_req   = 1'b1;
      trap_pc    = 32'h0000_4000;
      trap_cause = 32'h0000_0005;
      tick();
      trap_req = 1'b0;
      @(negedge clk);
      total++;
      if (csr_waddr_o !== A_MEPC) begin
         bad++;
         $display("FAIL reset_mid_epc: waddr=%h, expected %h", csr_waddr_o, A_MEPC);
      end
      tick();
      rst            = 1'b0;
      core_csr_waddr = A_MSTATUS;
      @(negedge clk);
      total++;
      if (csr_waddr_o !== A_MDIS || stall_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_hold: waddr=%h stall=%b, expected %h 0", csr_waddr_o, stall_o, A_MDIS);
      end
      tick();
      tick();
      rst            = 1'b1;
      core_csr_waddr = A_MDIS;
      @(negedge clk);
      total++;
      if (stall_o !== 1'b0 || csr_waddr_o !== A_MDIS || redirect_o !== 1'b0 ||
          ack_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_mid_idle: stall=%b waddr=%h redir=%b ack=%b pc=%h, expected 0 %h 0 0 0",
                  stall_o, csr_waddr_o, redirect_o, ack_o, redirect_pc_o, A_MDIS);
      end
      total++;
      if (csr_mem[A_MEPC] !== 32'h0000_4000) begin
         bad++;
         $display("FAIL reset_keeps_mepc: mepc=%h, expected 00004000", csr_mem[A_MEPC]);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_trap_basic();
      test_vectored();
      test_mret();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      tick();
      tick();
      total++;
      if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
         bad++;
         $display("FAIL leftover: writes=%0d redirects=%0d still expected, required 0 0",
                  exp_q.size(), exp_rd_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
